// File: rtl/mux_capture_fifo.sv
// -----------------------------------------------------------------------------
// mux_capture_fifo
//
// Captures the output word of an upstream 4:1 mux together with the selector
// value that produced it, and queues the pair in a first-word-fall-through
// FIFO for a downstream consumer. Words offered while the FIFO is full are
// rejected and tallied in a saturating drop counter.
//
// Ports
//   clk_i       rising-edge clock for all state
//   rst_ni      asynchronous active-low reset
//   data_i      upstream mux output word (DATA_WIDTH bits)
//   sel_i       selector that produced data_i, stored as a tag
//   valid_i     upstream word present this cycle
//   ready_o     FIFO can accept a word this cycle
//   data_o      head-of-FIFO data (0 when empty)
//   sel_o       head-of-FIFO selector tag (0 when empty)
//   valid_o     head entry is valid
//   ready_i     downstream accepts the head this cycle
//   count_o     current occupancy, 0..DEPTH
//   drop_cnt_o  saturating count of rejected words (sticks at 255)
//
// Handshake: a transfer happens on a rising clk_i edge exactly when valid and
// ready of the same channel are both 1 at that edge. ready_o depends only on
// registered state (never on valid_i), and valid_o depends only on registered
// state (never on ready_i), so neither side can form a combinational loop.
// -----------------------------------------------------------------------------
module mux_capture_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8      // power of 2, at least 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [1:0]              sel_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [1:0]              sel_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [7:0]              drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;   // {sel, data}

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    DROP_MAX   = 8'hFF;

    // Storage: deliberately not reset; the occupancy count decides what is valid.
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    drop_cnt;

    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Flow control derived from registered occupancy only.
    assign ready_o = (count != FULL_COUNT);
    assign valid_o = (count != '0);

    // When full, ready_o is 0, so a simultaneous pop never lets the push in.
    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    // Fall-through read straight from storage; zeroed when nothing is queued
    // so stale or uninitialised entries never leak out.
    assign head   = mem[rd_ptr];
    assign data_o = valid_o ? head[DATA_WIDTH-1:0] : '0;
    assign sel_o  = valid_o ? head[EW-1 -: 2]      : '0;

    assign count_o    = count;
    assign drop_cnt_o = drop_cnt;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {sel_i, data_i};
        end
    end

    // Pointers wrap by natural AW-bit overflow since DEPTH is a power of 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Every cycle a word is offered while full counts as one drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (valid_i && !ready_o && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: doc/mux_capture_fifo.md
MUX_CAPTURE_FIFO -- requirements
Module: mux_capture_fifo

Interface
REQ-001 The block SHALL have exactly one clock, clk_i; reset is asynchronous and active-low, rst_ni.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of the captured mux output word.
REQ-003 Parameter DEPTH, default 8, SHALL set the number of FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-004 clk_i  input  1  rising-edge clock for all state.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 data_i  input  DATA_WIDTH  upstream 4:1 mux output word (y_o of the mux stage).
REQ-007 sel_i  input  2  selector value that produced data_i, stored as a tag.
REQ-008 valid_i  input  1  upstream word is present this cycle.
REQ-009 ready_o  output  1  the FIFO can accept a word this cycle.
REQ-010 data_o  output  DATA_WIDTH  head-of-FIFO data.
REQ-011 sel_o  output  2  head-of-FIFO selector tag.
REQ-012 valid_o  output  1  the head entry is valid.
REQ-013 ready_i  input  1  the downstream stage accepts the head this cycle.
REQ-014 count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 drop_cnt_o  output  8  saturating count of rejected words.

Function
REQ-016 Push SHALL occur on a rising clk_i edge when valid_i=1 and ready_o=1; {sel_i,data_i} is written at the write pointer.
REQ-017 Pop SHALL occur on a rising clk_i edge when valid_o=1 and ready_i=1; the read pointer advances.
REQ-018 ready_o SHALL equal (count_o != DEPTH) and SHALL be a combinational function of registered state only, never of valid_i.
REQ-019 valid_o SHALL equal (count_o != 0).
REQ-020 Ordering SHALL be first-word-fall-through: data_o/sel_o show the head entry directly from storage with no read latency.
REQ-021 Latency: a word pushed into an empty FIFO at edge N SHALL appear on data_o/valid_o after edge N; there is no same-cycle bypass.
REQ-022 When valid_o=0, data_o and sel_o SHALL be driven to 0.
REQ-023 While valid_o=1 and ready_i=0, data_o and sel_o SHALL stay stable.
REQ-024 Simultaneous push and pop with 0<count_o<DEPTH SHALL leave count_o unchanged and advance both pointers.
REQ-025 Full with valid_i=1 and ready_i=1: the pop SHALL occur and the push SHALL be rejected, because ready_o=0; count_o becomes DEPTH-1.
REQ-026 Empty with valid_i=1 and ready_i=1: only the push SHALL occur; count_o becomes 1.
REQ-027 Each pointer SHALL wrap from DEPTH-1 to 0 by natural log2(DEPTH)-bit overflow.
REQ-028 Each cycle with valid_i=1 and ready_o=0 SHALL increment drop_cnt_o; drop_cnt_o SHALL saturate at 255 and SHALL never wrap.
REQ-029 Storage contents SHALL NOT be reset; only pointers, count and counters are reset.

Reset
REQ-030 Asserting rst_ni low SHALL immediately, without waiting for a clock edge, set the pointers to 0, count_o=0, drop_cnt_o=0, valid_o=0, data_o=0, sel_o=0 and ready_o=1.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; no pre-reset entry is ever output after reset.
REQ-032 The first push SHALL be accepted on the first rising edge after rst_ni deasserts.

Verification
REQ-033 Reset, then push 0x05/sel=2 with ready_i=0 -> after the next edge: valid_o=1, data_o=0x05, sel_o=2, count_o=1.
REQ-034 Push 8 words 0..7 with ready_i=0, then a 9th word 0xAA -> ready_o=0, count_o=8, drop_cnt_o=1; draining then yields 0..7 in order, and 0xAA never appears.
REQ-035 Hold count_o=3 and drive valid_i=1 and ready_i=1 for 20 cycles -> count_o stays 3, the output order matches the input order, and both pointers wrap twice with no loss.
REQ-036 Full FIFO, valid_i=1 and ready_i=1 for one cycle -> the head is popped, the new word is rejected, count_o=7 and drop_cnt_o increments.
REQ-037 Full FIFO with valid_i=1 held for 300 cycles -> drop_cnt_o=255 and holds.
REQ-038 Pull rst_ni low between clock edges while count_o=5 -> outputs take their reset values before the next edge; after release, valid_o=0 until a new push.
